// File: rtl/sd_pkg.sv
// Shared SD host definitions: CRC polynomials, block length and
// the DAT read controller state encoding.
package sd_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [6:0]  CRC7_POLY  = 7'h09;
  localparam int          NBYTES_DEF = 512;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CRC   = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;

  function automatic logic [6:0] crc7_step(
    input logic [6:0] crc,
    input logic       b
  );
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16 (x^16+x^12+x^5+1) for one DAT line.
// Ports: clk, rstn, clr (sync clear), en (shift one bit), din, crc.
module sd_crc16
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;

  assign fb = crc[15] ^ din;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc <= 16'h0;
    end else if (clr) begin
      crc <= 16'h0;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0);
    end
  end

endmodule

// File: rtl/sddat_rd_ctrl.sv
// SD DAT-line single-block reader: start-bit hunt, byte stream, CRC16/end check.
// Ports: clk, rstn, sdclk, sddat_i, start, width4 -> busy, done, timeout, crcerr, outen/outaddr/outbyte.
module sddat_rd_ctrl
  import sd_pkg::*;
#(
  parameter int TIMEOUT = 500000,
  parameter int NBYTES  = NBYTES_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sdclk,
  input  logic [3:0] sddat_i,
  input  logic       start,
  input  logic       width4,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic       crcerr,
  output logic       outen,
  output logic [8:0] outaddr,
  output logic [7:0] outbyte
);

  logic [2:0]  state;
  logic        sdclk_q;
  logic        w4;
  logic [23:0] tmo;
  logic [9:0]  cnt;
  logic [2:0]  bitc;
  logic [3:0]  crcc;
  logic [7:0]  sh;
  logic [15:0] rx      [4];
  logic [15:0] crc_out [4];

  logic       rise;
  logic [3:0] used;
  logic [3:0] crc_en;
  logic       crc_clr;
  logic       sbit;
  logic       blast;
  logic [7:0] bnxt;
  logic       crc_bad;
  logic       end_bad;

  assign rise    = sdclk & ~sdclk_q;
  assign used    = w4 ? 4'hF : 4'h1;
  assign crc_clr = (state == S_IDLE) && start;
  assign crc_en  = (rise && state == S_DATA) ? used : 4'h0;
  assign sbit    = w4 ? (sddat_i == 4'h0) : ~sddat_i[0];
  assign blast   = w4 ? bitc[0] : (bitc == 3'd7);
  assign bnxt    = w4 ? {sh[3:0], sddat_i} : {sh[6:0], sddat_i[0]};
  assign end_bad = |(~sddat_i & used);

  always_comb begin
    crc_bad = 1'b0;
    for (int l = 0; l < 4; l++)
      if (used[l] && crc_out[l] != rx[l])
        crc_bad = 1'b1;
  end

  for (genvar l = 0; l < 4; l++) begin : g_crc
    sd_crc16 u_crc (
      .clk  (clk),
      .rstn (rstn),
      .clr  (crc_clr),
      .en   (crc_en[l]),
      .din  (sddat_i[l]),
      .crc  (crc_out[l])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      sdclk_q <= 1'b0;
      w4      <= 1'b0;
      tmo     <= 24'h0;
      cnt     <= 10'h0;
      bitc    <= 3'h0;
      crcc    <= 4'h0;
      sh      <= 8'h0;
      for (int l = 0; l < 4; l++)
        rx[l] <= 16'h0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      crcerr  <= 1'b0;
      outen   <= 1'b0;
      outaddr <= 9'h0;
      outbyte <= 8'h0;
    end else begin
      sdclk_q <= sdclk;
      done    <= 1'b0;
      timeout <= 1'b0;
      crcerr  <= 1'b0;
      outen   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            w4    <= width4;
            tmo   <= 24'(TIMEOUT);
            cnt   <= 10'h0;
            bitc  <= 3'h0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rise) begin
            if (sbit) begin
              state <= S_DATA;
            end else if (tmo == 24'd1) begin
              done    <= 1'b1;
              timeout <= 1'b1;
              busy    <= 1'b0;
              state   <= S_IDLE;
            end else begin
              tmo <= tmo - 24'd1;
            end
          end
        end
        S_DATA: begin
          if (rise) begin
            sh   <= bnxt;
            bitc <= blast ? 3'h0 : bitc + 3'd1;
            if (blast) begin
              outen   <= 1'b1;
              outbyte <= bnxt;
              outaddr <= cnt[8:0];
              cnt     <= cnt + 10'd1;
              if (cnt == 10'(NBYTES - 1)) begin
                crcc  <= 4'h0;
                state <= S_CRC;
              end
            end
          end
        end
        S_CRC: begin
          if (rise) begin
            for (int l = 0; l < 4; l++)
              rx[l] <= {rx[l][14:0], sddat_i[l]};
            crcc <= crcc + 4'd1;
            if (crcc == 4'd15)
              state <= S_END;
          end
        end
        S_END: begin
          if (rise) begin
            crcerr <= crc_bad | end_bad;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sddat_rd_ctrl.sv
// Directed bench for sddat_rd_ctrl: 1/4-bit blocks, CRC/end errors,
// start-bit timeout, ignored restart and mid-block reset.
module tb_sddat_rd_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sdclk = 1'b0;
  logic [3:0] sddat = 4'hF;
  logic       start = 1'b0;
  logic       width4 = 1'b0;
  logic       busy, done, timeout, crcerr, outen;
  logic [8:0] outaddr;
  logic [7:0] outbyte;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes [512];
  logic [8:0] got_addr  [1024];
  logic [7:0] got_byte  [1024];
  int   n_strobe = 0;
  int   done_cnt = 0;
  logic last_tmo = 1'b0;
  logic last_crc = 1'b0;

  always #5 clk = ~clk;

  sddat_rd_ctrl #(.TIMEOUT(16), .NBYTES(512)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .sdclk   (sdclk),
    .sddat_i (sddat),
    .start   (start),
    .width4  (width4),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .crcerr  (crcerr),
    .outen   (outen),
    .outaddr (outaddr),
    .outbyte (outbyte)
  );

  always @(negedge clk) begin
    if (outen) begin
      if (n_strobe < 1024) begin
        got_addr[n_strobe] = outaddr;
        got_byte[n_strobe] = outbyte;
      end
      n_strobe++;
    end
    if (done) begin
      done_cnt++;
      last_tmo = timeout;
      last_crc = crcerr;
    end
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c,
                                           input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0);
  endfunction

  function automatic int strobe_errs(input int n);
    int e = 0;
    for (int i = 0; i < n; i++)
      if (got_addr[i] !== 9'(i) || got_byte[i] !== exp_bytes[i])
        e++;
    return e;
  endfunction

  task automatic clear_mon();
    n_strobe = 0;
    done_cnt = 0;
    last_tmo = 1'b0;
    last_crc = 1'b0;
  endtask

  task automatic sd_cycle(input logic [3:0] d);
    @(negedge clk);
    sddat = d;
    sdclk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sdclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done_cnt > 0) break;
      @(negedge clk);
    end
  endtask

  task automatic send_block(input bit w4, input logic [3:0] flip,
                            input logic [3:0] endbad,
                            input int restart_at, input int reset_at,
                            input bit use_ovr, input logic [15:0] ovr);
    logic [15:0] crc [4];
    logic [7:0]  b;
    logic [3:0]  d;
    for (int l = 0; l < 4; l++) crc[l] = 16'h0;
    for (int i = 0; i < 512; i++) begin
      b = exp_bytes[i];
      if (w4) begin
        for (int l = 0; l < 4; l++) begin
          crc[l] = crc_step(crc[l], b[4 + l]);
          crc[l] = crc_step(crc[l], b[l]);
        end
      end else begin
        for (int k = 7; k >= 0; k--) crc[0] = crc_step(crc[0], b[k]);
      end
    end
    if (use_ovr) crc[0] = ovr;
    for (int l = 0; l < 4; l++) if (flip[l]) crc[l][5] = ~crc[l][5];
    width4 = w4;
    pulse_start();
    width4 = ~w4;
    repeat (3) sd_cycle(4'hF);
    sd_cycle(w4 ? 4'h0 : {3'($urandom_range(0, 7)), 1'b0});
    for (int i = 0; i < 512; i++) begin
      if (i == restart_at) pulse_start();
      if (i == reset_at) begin
        @(negedge clk);
        rstn = 1'b0;
        return;
      end
      b = exp_bytes[i];
      if (w4) begin
        sd_cycle(b[7:4]);
        sd_cycle(b[3:0]);
      end else begin
        for (int k = 7; k >= 0; k--)
          sd_cycle({3'($urandom_range(0, 7)), b[k]});
      end
    end
    for (int k = 15; k >= 0; k--) begin
      if (w4) d = {crc[3][k], crc[2][k], crc[1][k], crc[0][k]};
      else    d = {3'($urandom_range(0, 7)), crc[0][k]};
      sd_cycle(d);
    end
    sd_cycle(w4 ? ~endbad : {3'($urandom_range(0, 7)), ~endbad[0]});
    sd_cycle(4'hF);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, timeout, crcerr, outen} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {busy, done, timeout, crcerr, outen});
    end
    checks++;
    if ({outaddr, outbyte} !== 17'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h want 0/0", outaddr, outbyte);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_1bit_ff();
    int e;
    for (int i = 0; i < 512; i++) exp_bytes[i] = 8'hFF;
    clear_mon();
    send_block(1'b0, 4'h0, 4'h0, -1, -1, 1'b1, 16'h7FA1);
    wait_done();
    e = strobe_errs(512);
    checks++;
    if (n_strobe !== 512) begin
      errors++;
      $display("FAIL 1bit_count got %0d want 512", n_strobe);
    end
    checks++;
    if (e !== 0) begin
      errors++;
      $display("FAIL 1bit_bytes got %0d bad want 0", e);
    end
    checks++;
    if (done_cnt !== 1 || last_crc !== 1'b0 || last_tmo !== 1'b0) begin
      errors++;
      $display("FAIL 1bit_status got done=%0d crc=%b tmo=%b want 1/0/0",
               done_cnt, last_crc, last_tmo);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL 1bit_busy got %b want 0", busy);
    end
  endtask

  task automatic test_4bit_ramp();
    int e;
    for (int i = 0; i < 512; i++) exp_bytes[i] = 8'(i);
    clear_mon();
    send_block(1'b1, 4'h0, 4'h0, -1, -1, 1'b0, 16'h0);
    wait_done();
    e = strobe_errs(512);
    checks++;
    if (n_strobe !== 512 || e !== 0) begin
      errors++;
      $display("FAIL 4bit_bytes got n=%0d bad=%0d want 512/0", n_strobe, e);
    end
    checks++;
    if (done_cnt !== 1 || last_crc !== 1'b0 || last_tmo !== 1'b0) begin
      errors++;
      $display("FAIL 4bit_status got done=%0d crc=%b tmo=%b want 1/0/0",
               done_cnt, last_crc, last_tmo);
    end
  endtask

  task automatic test_crc_errors();
    int e;
    for (int i = 0; i < 512; i++) exp_bytes[i] = 8'(i);
    clear_mon();
    send_block(1'b1, 4'b0100, 4'h0, -1, -1, 1'b0, 16'h0);
    wait_done();
    e = strobe_errs(512);
    checks++;
    if (n_strobe !== 512 || e !== 0) begin
      errors++;
      $display("FAIL crcflip_bytes got n=%0d bad=%0d want 512/0",
               n_strobe, e);
    end
    checks++;
    if (done_cnt !== 1 || last_crc !== 1'b1) begin
      errors++;
      $display("FAIL crcflip_status got done=%0d crc=%b want 1/1",
               done_cnt, last_crc);
    end
    clear_mon();
    send_block(1'b1, 4'h0, 4'b0010, -1, -1, 1'b0, 16'h0);
    wait_done();
    checks++;
    if (n_strobe !== 512 || done_cnt !== 1 || last_crc !== 1'b1) begin
      errors++;
      $display("FAIL endbit_status got n=%0d done=%0d crc=%b want 512/1/1",
               n_strobe, done_cnt, last_crc);
    end
  endtask

  task automatic test_timeout();
    clear_mon();
    width4 = 1'b0;
    pulse_start();
    repeat (15) sd_cycle(4'hF);
    checks++;
    if (done_cnt !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early got done=%0d busy=%b want 0/1",
               done_cnt, busy);
    end
    sd_cycle(4'hF);
    checks++;
    if (done_cnt !== 1 || last_tmo !== 1'b1 || last_crc !== 1'b0) begin
      errors++;
      $display("FAIL tmo_at16 got done=%0d tmo=%b crc=%b want 1/1/0",
               done_cnt, last_tmo, last_crc);
    end
    checks++;
    if (n_strobe !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle got n=%0d busy=%b want 0/0", n_strobe, busy);
    end
  endtask

  task automatic test_restart_ignored();
    int e;
    for (int i = 0; i < 512; i++) exp_bytes[i] = 8'(i * 5 + 1);
    clear_mon();
    send_block(1'b1, 4'h0, 4'h0, 100, -1, 1'b0, 16'h0);
    wait_done();
    e = strobe_errs(512);
    checks++;
    if (n_strobe !== 512 || e !== 0 || done_cnt !== 1 || last_crc !== 1'b0)
    begin
      errors++;
      $display("FAIL restart got n=%0d bad=%0d done=%0d crc=%b want 512/0/1/0",
               n_strobe, e, done_cnt, last_crc);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    for (int i = 0; i < 512; i++) exp_bytes[i] = 8'(i * 7 + 3);
    clear_mon();
    send_block(1'b1, 4'h0, 4'h0, -1, 200, 1'b0, 16'h0);
    @(negedge clk);
    checks++;
    if ({busy, done, timeout, crcerr, outen, outaddr, outbyte} !== 22'h0)
    begin
      errors++;
      $display("FAIL midrst_outs got %b want 0",
               {busy, done, timeout, crcerr, outen, outaddr, outbyte});
    end
    checks++;
    if (n_strobe !== 200) begin
      errors++;
      $display("FAIL midrst_count got %0d want 200", n_strobe);
    end
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL midrst_nodone got %0d want 0", done_cnt);
    end
    clear_mon();
    send_block(1'b1, 4'h0, 4'h0, -1, -1, 1'b0, 16'h0);
    wait_done();
    e = strobe_errs(512);
    checks++;
    if (n_strobe !== 512 || e !== 0 || done_cnt !== 1 || last_crc !== 1'b0)
    begin
      errors++;
      $display("FAIL midrst_clean got n=%0d bad=%0d done=%0d crc=%b want 512/0/1/0",
               n_strobe, e, done_cnt, last_crc);
    end
  endtask

  initial begin
    test_reset();
    test_1bit_ff();
    test_4bit_ramp();
    test_crc_errors();
    test_timeout();
    test_restart_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sddat_rd_ctrl.md
Name: sddat_rd_ctrl

Overview:
Receives one 512-byte read data block from the SD card DAT lines after a CMD17 issued through the command-line controller. Runs beside the command controller and samples DAT on rising edges of the sdclk that the command controller generates. Supports 1-bit and 4-bit bus modes and checks CRC16 on each used line. Delivers bytes as an indexed write stream to the sector buffer, then reports completion, timeout or CRC error to the read sequencer.

Parameters:
TIMEOUT, 500000, max sdclk rising edges waited for the start bit (24-bit counter; must be ≥1)
NBYTES, 512, block length in bytes (fixed for SDHC/SDXC)

Ports:
clk  input  1  system clock
rstn  input  1  reset, asynchronous, active-low
sdclk  input  1  SD clock from the command controller; a rising edge is detected in the clk domain
sddat_i  input  4  DAT[3:0] from the pads; DAT0 only in 1-bit mode
start  input  1  one-cycle request to receive one block; sampled only when busy=0
width4  input  1  1 = 4-bit mode, 0 = 1-bit mode; latched on an accepted start
busy  output  1  transfer in progress
done  output  1  one-cycle completion pulse
timeout  output  1  valid with done; no start bit seen
crcerr  output  1  valid with done; CRC16 mismatch or bad end bit
outen  output  1  one-cycle byte strobe
outaddr  output  9  byte index 0..511, valid with outen
outbyte  output  8  byte value, valid with outen

Behaviour:
- Reset values: busy, done, timeout, crcerr, outen = 0; outaddr, outbyte = 0; state = IDLE; CRC registers = 0.
- Edge detect: register sdclk. rise = sdclk & ~sdclk_q. All DAT sampling happens only on clk cycles where rise=1. Data is sampled with 1-clk latency after the sdclk edge.
- done, timeout, crcerr and outen default to 0 every cycle. Each is a single-cycle pulse.
- States:
  - IDLE: on start, set busy=1, latch width4, load tmo=TIMEOUT, clear the CRCs, byte count and bit count, then go to WAIT_START.
  - WAIT_START, on rise: a start bit is DAT0=0 in 1-bit mode, or DAT[3:0]=0000 in 4-bit mode.
    - Start bit seen: go to DATA.
    - No start bit and tmo=1: done=1, timeout=1, busy=0, go to IDLE.
    - Otherwise: decrement tmo.
  - DATA, on rise:
    - Shift the sample MSB-first: 1 bit per rise in 1-bit mode, 1 nibble per rise in 4-bit mode (high nibble first).
    - Update each used line's CRC16 with that line's bit.
    - On the rise that completes a byte (8th in 1-bit mode, 2nd in 4-bit mode), on the next clk: outen=1, outbyte=byte, outaddr=count; then count += 1.
    - After byte NBYTES-1, go to CRC.
  - CRC: 16 rises. Shift the received bits per line MSB-first into a compare register.
  - END: 1 rise. The end bit must be 1 on every used line.
    - crcerr=1 if any used line's computed CRC ≠ received CRC, or any end bit = 0.
    - Then done=1, busy=0, go to IDLE.
- CRC16: polynomial x^16+x^12+x^5+1, init 0. Serial update: fb = crc[15]^bit; crc = {crc[14:0],0} ^ (fb ? 16'h1021 : 0). Unused lines in 1-bit mode are ignored.
- busy falls in the same cycle done rises, so a new start is accepted the next cycle.
- start while busy is ignored; width4 changes mid-transfer are ignored.
- Bytes are output even if the CRC later fails; the consumer discards the block on crcerr.
- sdclk stopping mid-transfer: the block waits indefinitely. There is no data-phase timeout; the sequencer handles it via reset.
- rstn asserted mid-operation returns everything to reset values immediately, with no done pulse.
- Counter widths: byte count 10 bits (compare with NBYTES-1), bit count 3 bits, CRC-phase counter 4 bits, tmo 24 bits.

Decomposition:
- Shared package sd_pkg holds:
  - CRC16 polynomial constant 16'h1021
  - NBYTES default
  - state encoding IDLE/WAIT_START/DATA/CRC/END
  - the CRC7 function already used by the command path
- One sub-module sd_crc16: clear, enable, bit in, 16-bit CRC out; serial update. Instantiated 4×, one per DAT line.

Test Plan:
- 1-bit mode, 512×8'hFF, card CRC 16'h7FA1, end bit 1 -> 512 outen pulses with outaddr 0..511 and outbyte FF; done=1, crcerr=0, timeout=0.
- 4-bit mode, byte i = i[7:0], correct per-line CRCs -> outbyte = outaddr[7:0] for all 512 strobes; done, crcerr=0.
- 4-bit mode, one CRC bit flipped on DAT2 (or end bit 0 on DAT1) -> all 512 bytes delivered, then done=1, crcerr=1.
- TIMEOUT=16, DAT held 1 -> done=1, timeout=1 exactly at the 16th sdclk rise after start; no outen; busy=0.
- start pulsed again at byte 100 -> ignored, transfer completes normally. rstn pulsed at byte 200 -> all outputs 0, no done; next start with a valid block -> clean reception.
